// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA test-pattern generator.
//   - mode_e      : selectable test pattern
//   - VGA_*       : default 640x480@60 timing (pixel counts / line counts)
//   - BAR_*       : colour-bar index constants, left to right
//   - bar_rgb()   : maps a bar index to a {r,g,b} on/off mask
//   - max3()      : widest of three channel widths
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic [2:0] BAR_WHITE   = 3'd0;
  localparam logic [2:0] BAR_YELLOW  = 3'd1;
  localparam logic [2:0] BAR_CYAN    = 3'd2;
  localparam logic [2:0] BAR_GREEN   = 3'd3;
  localparam logic [2:0] BAR_MAGENTA = 3'd4;
  localparam logic [2:0] BAR_RED     = 3'd5;
  localparam logic [2:0] BAR_BLUE    = 3'd6;
  localparam logic [2:0] BAR_BLACK   = 3'd7;

  // Returns {r_on, g_on, b_on}; each channel is either fully on or off.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      BAR_WHITE:   return 3'b111;
      BAR_YELLOW:  return 3'b110;
      BAR_CYAN:    return 3'b011;
      BAR_GREEN:   return 3'b010;
      BAR_MAGENTA: return 3'b101;
      BAR_RED:     return 3'b100;
      BAR_BLUE:    return 3'b001;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability counter. The debounced level
// only changes after DEBOUNCE_CYCLES consecutive synchronised samples that
// differ from it; a one-clock pulse marks each accepted rising level.
// Ports:
//   clock    in  system clock
//   reset_n  in  synchronous active-low reset
//   btn_raw  in  raw asynchronous button
//   rise     out one-clock pulse on an accepted 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Any sample equal to the current level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// Parametrised VGA timing and test-pattern generator. A clock divider makes
// the pixel tick; h/v counters produce sync, and the selected pattern gives
// the colour. Everything on the pins is registered on the tick from the same
// h/v value, so sync, colour, active and frame_start are aligned.
// The button (debounced) sets a sticky pending flag; the mode only advances
// at the tick of pixel (0,0), so it never changes mid-frame.
// Optional feature macro: VGA_MOVING_SQUARE_EN adds the bouncing-square mode
// (modes 0->1->2->3->0); without it modes cycle 0->1->2->0.
// Ports:
//   clock, reset_n              system clock, synchronous active-low reset
//   Btn1                        raw mode-advance button
//   Horizonatalsync/Verticalsync sync outputs (asserted level = *_POL)
//   red/green/blue              pixel colour
//   active                      registered pixel is visible
//   frame_start                 one-clock pulse with registered pixel (0,0)
// -----------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int H_FP            = VGA_H_FP,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BP            = VGA_H_BP,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter int V_FP            = VGA_V_FP,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BP            = VGA_V_BP,
  parameter bit HSYNC_POL       = 1'b0,
  parameter bit VSYNC_POL       = 1'b0,
  parameter int R_W             = 3,
  parameter int G_W             = 3,
  parameter int B_W             = 2,
  parameter int CLK_DIV         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CHECK_LOG2      = 5,
  parameter int SQ_SIZE         = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           Btn1,
  output logic           Horizonatalsync,
  output logic           Verticalsync,
  output logic [R_W-1:0] red,
  output logic [G_W-1:0] green,
  output logic [B_W-1:0] blue,
  output logic           active,
  output logic           frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAX_W     = max3(R_W, G_W, B_W);
  localparam int GRAD_RAW  = H_ACTIVE / (1 << MAX_W);
  localparam int GRAD_STEP = (GRAD_RAW < 1) ? 1 : GRAD_RAW;
  localparam int GW        = (GRAD_STEP > 1) ? $clog2(GRAD_STEP) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [GW-1:0] GRAD_LAST = GW'(GRAD_STEP - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  mode_e            mode_q, mode_d, mode_nxt, mode_cur;
  logic             pending_q, pending_d;
  logic [MAX_W-1:0] level_q, level_d;
  logic [GW-1:0]    gstep_q, gstep_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             active_q, active_d, fs_q, fs_d;
  logic [R_W-1:0]   red_q, red_d;
  logic [G_W-1:0]   green_q, green_d;
  logic [B_W-1:0]   blue_q, blue_d;
  logic             tick, h_last, v_last, origin, load_mode, visible;
  logic             btn_rise;
  logic [2:0]       bar_idx, bar_mask;
  logic             in_square;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn1 (
    .clock  (clock),
    .reset_n(reset_n),
    .btn_raw(Btn1),
    .rise   (btn_rise)
  );

`ifdef VGA_MOVING_SQUARE_EN
  localparam logic [HW-1:0] SX_MAX = HW'(H_ACTIVE - SQ_SIZE);
  localparam logic [VW-1:0] SY_MAX = VW'(V_ACTIVE - SQ_SIZE);
  localparam logic [HW-1:0] SQ_H   = HW'(SQ_SIZE);
  localparam logic [VW-1:0] SQ_V   = VW'(SQ_SIZE);

  logic [HW-1:0] sx_q, sx_d;
  logic [VW-1:0] sy_q, sy_d;
  logic          sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  // The square moves once per displayed square frame, on the last tick of the
  // frame, so the first square frame shows the position it was entered with.
  always_comb begin
    sx_d     = sx_q;
    sy_d     = sy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    if (tick && h_last && v_last && mode_q == MODE_SQUARE) begin
      if (!sx_neg_q) begin
        if (sx_q == SX_MAX) begin sx_neg_d = 1'b1; sx_d = sx_q - 1'b1; end
        else sx_d = sx_q + 1'b1;
      end else begin
        if (sx_q == '0) begin sx_neg_d = 1'b0; sx_d = sx_q + 1'b1; end
        else sx_d = sx_q - 1'b1;
      end
      if (!sy_neg_q) begin
        if (sy_q == SY_MAX) begin sy_neg_d = 1'b1; sy_d = sy_q - 1'b1; end
        else sy_d = sy_q + 1'b1;
      end else begin
        if (sy_q == '0) begin sy_neg_d = 1'b0; sy_d = sy_q + 1'b1; end
        else sy_d = sy_q - 1'b1;
      end
    end
    in_square = (h_q >= sx_q) && ((h_q - sx_q) < SQ_H) &&
                (v_q >= sy_q) && ((v_q - sy_q) < SQ_V);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sx_q     <= '0;
      sy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end
`else
  assign in_square = 1'b0;
`endif

  always_comb begin
    tick   = (div_q == DIV_LAST);
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    origin = (h_q == '0) && (v_q == '0);

    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end

    case (mode_q)
      MODE_BARS:     mode_nxt = MODE_CHECKER;
      MODE_CHECKER:  mode_nxt = MODE_GRADIENT;
`ifdef VGA_MOVING_SQUARE_EN
      MODE_GRADIENT: mode_nxt = MODE_SQUARE;
`else
      MODE_GRADIENT: mode_nxt = MODE_BARS;
`endif
      default:       mode_nxt = MODE_BARS;
    endcase

    // Pixel (0,0) is already rendered in the newly selected mode.
    load_mode = tick && origin && pending_q;
    mode_d    = load_mode ? mode_nxt : mode_q;
    mode_cur  = mode_d;
    pending_d = pending_q;
    if (load_mode) pending_d = 1'b0;
    if (btn_rise)  pending_d = 1'b1;

    // Gradient level tracks the current h: level = h / GRAD_STEP.
    level_d = level_q;
    gstep_d = gstep_q;
    if (tick) begin
      if (h_last) begin
        level_d = '0;
        gstep_d = '0;
      end else if (gstep_q == GRAD_LAST) begin
        level_d = level_q + 1'b1;
        gstep_d = '0;
      end else begin
        gstep_d = gstep_q + 1'b1;
      end
    end

    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (h_q >= HW'((k * H_ACTIVE) / 8)) bar_idx = bar_idx + 3'd1;
    bar_mask = bar_rgb(bar_idx);

    visible = (h_q < H_ACT) && (v_q < V_ACT);

    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    fs_d     = tick && origin;
    if (tick) begin
      hsync_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      active_d = visible;
      red_d    = '0;
      green_d  = '0;
      blue_d   = '0;
      if (visible) begin
        case (mode_cur)
          MODE_BARS: begin
            red_d   = {R_W{bar_mask[2]}};
            green_d = {G_W{bar_mask[1]}};
            blue_d  = {B_W{bar_mask[0]}};
          end
          MODE_CHECKER: begin
            if (h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2]) begin
              red_d   = '1;
              green_d = '1;
              blue_d  = '1;
            end
          end
          MODE_GRADIENT: begin
            red_d   = level_q[MAX_W-1 -: R_W];
            green_d = level_q[MAX_W-1 -: G_W];
            blue_d  = level_q[MAX_W-1 -: B_W];
          end
          default: begin
            if (in_square) begin
              red_d   = '1;
              green_d = '1;
              blue_d  = '1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= MODE_BARS;
      pending_q <= 1'b0;
      level_q   <= '0;
      gstep_q   <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      active_q  <= 1'b0;
      fs_q      <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      gstep_q   <= gstep_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      fs_q      <= fs_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign Horizonatalsync = hsync_q;
  assign Verticalsync    = vsync_q;
  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign active          = active_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Small-timing bench: 24x12 total raster, 16x8 visible, one pixel per clock.
// Each pixel presented by the DUT is predicted from the raster position and
// the bench's own idea of mode/pending/square position, queued, and compared.
// Output word layout: {hsync, vsync, active, frame_start, r[2:0], g[2:0], b[1:0]}.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int CHECK_LOG2 = 1;
  localparam int SQ_SIZE    = 4;
  localparam int DEBOUNCE   = 4;
  localparam int W          = 12;
  localparam logic [W-1:0] RESET_OUT = 12'hC00;
  // Bars left to right as {r3,g3,b2}: white yellow cyan green magenta red blue black.
  localparam logic [7:0] BAR_TBL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       Btn1 = 1'b0;
  logic       hsync, vsync, active, frame_start;
  logic [2:0] red, green;
  logic [1:0] blue;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Bench model state: next raster position, presented position, mode, square.
  int nh, nv, ph, pv, m_mode, sx, sy;
  bit m_pending, sx_neg, sy_neg;

  vga_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .R_W(3), .G_W(3), .B_W(2),
    .CLK_DIV(1), .DEBOUNCE_CYCLES(DEBOUNCE),
    .CHECK_LOG2(CHECK_LOG2), .SQ_SIZE(SQ_SIZE)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .Btn1           (Btn1),
    .Horizonatalsync(hsync),
    .Verticalsync   (vsync),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .active         (active),
    .frame_start    (frame_start)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic int next_mode(input int m);
`ifdef VGA_MOVING_SQUARE_EN
    return (m + 1) % 4;
`else
    return (m + 1) % 3;
`endif
  endfunction

  function automatic logic [W-1:0] exp_pix(input int h, input int v);
    logic hs, vs, act, fs;
    logic [7:0] rgb;
    int lvl;
    hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    act = (h < H_ACTIVE) && (v < V_ACTIVE);
    fs  = (h == 0) && (v == 0);
    rgb = 8'h00;
    if (act) begin
      case (m_mode)
        0: rgb = BAR_TBL[(h * 8) / H_ACTIVE];
        1: if ((((h >> CHECK_LOG2) ^ (v >> CHECK_LOG2)) & 1) == 1) rgb = 8'hFF;
        2: begin
          lvl = h / (H_ACTIVE / 8);
          rgb = {lvl[2:0], lvl[2:0], lvl[2:1]};
        end
        default: if (h >= sx && h < sx + SQ_SIZE && v >= sy && v < sy + SQ_SIZE) rgb = 8'hFF;
      endcase
    end
    return {hs, vs, act, fs, rgb};
  endfunction

  task automatic model_reset();
    nh = 0; nv = 0; m_mode = 0; m_pending = 1'b0;
    sx = 0; sy = 0; sx_neg = 1'b0; sy_neg = 1'b0;
  endtask

  task automatic model_next(output logic [W-1:0] e);
    if (nh == 0 && nv == 0 && m_pending) begin
      m_mode = next_mode(m_mode);
      m_pending = 1'b0;
    end
    ph = nh; pv = nv;
    e = exp_pix(nh, nv);
    if (nh == H_TOTAL - 1 && nv == V_TOTAL - 1 && m_mode == 3) begin
      if (!sx_neg) begin if (sx == H_ACTIVE - SQ_SIZE) begin sx_neg = 1'b1; sx--; end else sx++; end
      else begin if (sx == 0) begin sx_neg = 1'b0; sx++; end else sx--; end
      if (!sy_neg) begin if (sy == V_ACTIVE - SQ_SIZE) begin sy_neg = 1'b1; sy--; end else sy++; end
      else begin if (sy == 0) begin sy_neg = 1'b0; sy++; end else sy--; end
    end
    nh++;
    if (nh == H_TOTAL) begin
      nh = 0; nv++;
      if (nv == V_TOTAL) nv = 0;
    end
  endtask

  function automatic logic [W-1:0] dut_out();
    return {hsync, vsync, active, frame_start, red, green, blue};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e, got;
    reset_n = 1'b0;
    Btn1 = 1'b0;
    repeat (3) @(negedge clock);
    exp_q.push_back(RESET_OUT);
    got = dut_out(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL reset: got %h expected %h", got, e); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_sync_bars();
    logic [W-1:0] e, got;
    int hs_cnt, vs_cnt, fs_cnt;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL sync_bars pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
      if (hsync == 1'b0) hs_cnt++;
      if (vsync == 1'b0) vs_cnt++;
      if (frame_start == 1'b1) fs_cnt++;
      if (ph == H_TOTAL - 1) begin
        n_tests++;
        if (hs_cnt != H_SYNC) begin n_fail++; $display("FAIL hsync_width line %0d: got %0d expected %0d", pv, hs_cnt, H_SYNC); end
        hs_cnt = 0;
      end
    end
    n_tests++;
    if (vs_cnt != 2 * V_SYNC * H_TOTAL) begin n_fail++; $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, 2 * V_SYNC * H_TOTAL); end
    n_tests++;
    if (fs_cnt != 2) begin n_fail++; $display("FAIL frame_start_count: got %0d expected 2", fs_cnt); end
  endtask

  task automatic test_short_press();
    logic [W-1:0] e, got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Btn1 = (i >= 40 && i < 42);
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL short_press pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
  endtask

  task automatic test_mode_advance();
    logic [W-1:0] e, got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Btn1 = (i >= 40 && i < 50);
      if (i == 40) m_pending = 1'b1;
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL mode_advance pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
  endtask

  task automatic test_double_press();
    logic [W-1:0] e, got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Btn1 = (i >= 20 && i < 30) || (i >= 80 && i < 90);
      if (i == 20) m_pending = 1'b1;
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL double_press pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e, got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Btn1 = (i >= 50 && i < 60);
      if (i == 50) m_pending = 1'b1;
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL wrap mode %0d pix(%0d,%0d): got %h expected %h", m_mode, ph, pv, got, e); end
    end
  endtask

  task automatic test_square();
    logic [W-1:0] e, got;
    for (int i = 0; i < 16 * FRAME; i++) begin
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL square sq(%0d,%0d) pix(%0d,%0d): got %h expected %h", sx, sy, ph, pv, got, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] e, got;
    for (int i = 0; i < 2 * FRAME; i++) begin
      Btn1 = (i >= 30 && i < 40);
      if (i == 30) m_pending = 1'b1;
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL pre_reset pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
    for (int i = 0; i < FRAME && !(nh == 10 && nv == 3); i++) begin
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL pre_reset pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
    reset_n = 1'b0;
    exp_q.push_back(RESET_OUT);
    @(negedge clock);
    got = dut_out(); e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", got, e); end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      model_next(e); exp_q.push_back(e);
      @(negedge clock);
      got = dut_out(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL after_reset pix(%0d,%0d): got %h expected %h", ph, pv, got, e); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    test_reset();
    test_sync_bars();
    test_short_press();
    test_mode_advance();
    test_double_press();
    test_wrap();
`ifdef VGA_MOVING_SQUARE_EN
    test_square();
    test_wrap();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
